// File: rtl/tlul_pkg.sv
// Minimal TL-UL bus types shared by crossbar sockets and device endpoints.
// Single-beat, 32-bit data, 8-bit source id.
package tlul_pkg;

  localparam logic [2:0] PutFullData    = 3'h0;
  localparam logic [2:0] PutPartialData = 3'h1;
  localparam logic [2:0] Get            = 3'h4;
  localparam logic [2:0] AccessAck      = 3'h0;
  localparam logic [2:0] AccessAckData  = 3'h1;

  typedef struct packed {
    logic        a_valid;
    logic [2:0]  a_opcode;
    logic [2:0]  a_param;
    logic [1:0]  a_size;
    logic [7:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    logic        d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic        d_valid;
    logic [2:0]  d_opcode;
    logic [2:0]  d_param;
    logic [1:0]  d_size;
    logic [7:0]  d_source;
    logic [0:0]  d_sink;
    logic [31:0] d_data;
    logic [7:0]  d_user;
    logic        d_error;
    logic        a_ready;
  } tl_d2h_t;

endpackage

// File: rtl/tlul_reg_pkg.sv
// Shared types and constants for the TL-UL register responder.
// Opcodes alias the bus package so both stay in sync.
package tlul_reg_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_e;

  localparam logic [2:0] OpPutFull = tlul_pkg::PutFullData;
  localparam logic [2:0] OpPutPart = tlul_pkg::PutPartialData;
  localparam logic [2:0] OpGet     = tlul_pkg::Get;
  localparam logic [2:0] OpAck     = tlul_pkg::AccessAck;
  localparam logic [2:0] OpAckData = tlul_pkg::AccessAckData;

  localparam logic [31:0] ErrData = 32'hFFFF_FFFF;

  // Byte lanes touched by an access of 2^size bytes at offset off.
  function automatic logic [3:0] cover_mask(
    input logic [1:0] size,
    input logic [1:0] off
  );
    logic [3:0] m;
    case (size)
      2'd0:    m = 4'b0001 << off;
      2'd1:    m = off[1] ? 4'b1100 : 4'b0011;
      default: m = 4'b1111;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/tlul_req_check.sv
// Combinational legality check of a TL-UL A-channel request
// against a register window of RegBytes bytes.
module tlul_req_check
  import tlul_reg_pkg::*;
#(
  parameter int AW       = 8,
  parameter int RegBytes = 64
) (
  input  logic [2:0]    i_opcode,
  input  logic [1:0]    i_size,
  input  logic [AW-1:0] i_addr,
  input  logic [3:0]    i_mask,
  output logic          o_err
);

  logic [3:0] w_cover;
  logic       w_bad_op;
  logic       w_bad_size;
  logic       w_misalign;
  logic       w_mask_out;
  logic       w_full_mis;
  logic       w_range;

  assign w_cover = cover_mask(i_size, i_addr[1:0]);

  assign w_bad_op = !(i_opcode inside
    {OpGet, OpPutFull, OpPutPart});

  assign w_bad_size = i_size > 2'd2;

  always_comb begin
    w_misalign = 1'b0;
    unique case (1'b1)
      (i_size == 2'd1): w_misalign = i_addr[0];
      (i_size == 2'd2): w_misalign = |i_addr[1:0];
      default:          w_misalign = 1'b0;
    endcase
  end

  assign w_mask_out = |(i_mask & ~w_cover);

  assign w_full_mis = (i_opcode == OpPutFull)
                    && (i_mask != w_cover);

  assign w_range = 32'(i_addr) >= 32'(RegBytes);

  assign o_err = w_bad_op | w_bad_size | w_misalign
               | w_mask_out | w_full_mis | w_range;

endmodule

// File: rtl/tlul_reg_responder.sv
// TL-UL device endpoint turning one A request into one register
// access and exactly one D response; one transaction in flight.
module tlul_reg_responder
  import tlul_reg_pkg::*;
#(
  parameter int AW       = 8,
  parameter int RegBytes = 64,
  parameter int Timeout  = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  tlul_pkg::tl_h2d_t tl_i,
  output tlul_pkg::tl_d2h_t tl_o,
  output logic              reg_req_o,
  output logic              reg_we_o,
  output logic [AW-1:0]     reg_addr_o,
  output logic [31:0]       reg_wdata_o,
  output logic [3:0]        reg_be_o,
  input  logic              reg_ready_i,
  input  logic [31:0]       reg_rdata_i,
  input  logic              reg_error_i
);

  state_e r_state;
  state_e w_state_nxt;

  logic [2:0]    r_opcode;
  logic [1:0]    r_size;
  logic [7:0]    r_source;
  logic [AW-1:0] r_addr;
  logic [3:0]    r_mask;
  logic [31:0]   r_data;
  logic [31:0]   r_rdata;
  logic          r_err;
  logic [7:0]    r_cnt;

  logic w_chk_err;
  logic w_a_fire;
  logic w_timeout;
  logic w_is_get;
  logic w_a_ready;
  logic w_d_valid;
  logic w_req;
  logic w_unused_tl;

  tlul_req_check #(
    .AW       (AW),
    .RegBytes (RegBytes)
  ) u_check (
    .i_opcode (tl_i.a_opcode),
    .i_size   (tl_i.a_size),
    .i_addr   (tl_i.a_address[AW-1:0]),
    .i_mask   (tl_i.a_mask),
    .o_err    (w_chk_err)
  );

  assign w_unused_tl = ^{tl_i.a_param, tl_i.a_address};

  assign w_a_fire = (r_state == IDLE) & tl_i.a_valid;

  assign w_timeout = (r_state == ACCESS) & ~reg_ready_i
                   & (r_cnt == 8'(Timeout - 1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_a_ready   = 1'b0;
    w_d_valid   = 1'b0;
    w_req       = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_a_ready = 1'b1;
        if (tl_i.a_valid)
          w_state_nxt = w_chk_err ? RESP : ACCESS;
      end
      ACCESS: begin
        w_req = 1'b1;
        if (reg_ready_i || w_timeout)
          w_state_nxt = RESP;
      end
      RESP: begin
        w_d_valid = 1'b1;
        if (tl_i.d_ready)
          w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_opcode <= '0;
      r_size   <= '0;
      r_source <= '0;
      r_addr   <= '0;
      r_mask   <= '0;
      r_data   <= '0;
      r_rdata  <= '0;
      r_err    <= 1'b0;
    end else begin
      if (w_a_fire) begin
        r_opcode <= tl_i.a_opcode;
        r_size   <= tl_i.a_size;
        r_source <= tl_i.a_source;
        r_addr   <= tl_i.a_address[AW-1:0];
        r_mask   <= tl_i.a_mask;
        r_data   <= tl_i.a_data;
        r_rdata  <= '0;
        r_err    <= w_chk_err;
      end
      if (r_state == ACCESS) begin
        if (reg_ready_i) begin
          r_rdata <= reg_rdata_i;
          r_err   <= reg_error_i;
        end else if (w_timeout) begin
          r_rdata <= '0;
          r_err   <= 1'b1;
        end
      end
    end
  end

  // Counts unanswered ACCESS cycles; zero whenever not waiting.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)
      r_cnt <= '0;
    else if ((r_state == ACCESS) && !reg_ready_i && !w_timeout)
      r_cnt <= r_cnt + 8'd1;
    else
      r_cnt <= '0;
  end

  assign w_is_get = (r_opcode == OpGet);

  assign reg_req_o   = w_req;
  assign reg_we_o    = ~w_is_get;
  assign reg_addr_o  = {r_addr[AW-1:2], 2'b00};
  assign reg_wdata_o = r_data;
  assign reg_be_o    = r_mask;

  always_comb begin
    tl_o          = '0;
    tl_o.a_ready  = w_a_ready;
    tl_o.d_valid  = w_d_valid;
    tl_o.d_opcode = w_is_get ? OpAckData : OpAck;
    tl_o.d_size   = r_size;
    tl_o.d_source = r_source;
    tl_o.d_error  = r_err;
    tl_o.d_data   = w_is_get ? (r_err ? ErrData : r_rdata)
                             : 32'h0;
  end

endmodule

// File: tb/tb_tlul_reg_responder.sv
// Scoreboard bench for tlul_reg_responder: directed requests,
// a register-side model and a D-channel monitor.
module tb_tlul_reg_responder;
  import tlul_pkg::*;

  localparam int AW       = 8;
  localparam int RegBytes = 64;
  localparam int Timeout  = 16;

  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  tl_h2d_t tl_i;
  tl_d2h_t tl_o;
  logic          reg_req_o;
  logic          reg_we_o;
  logic [AW-1:0] reg_addr_o;
  logic [31:0]   reg_wdata_o;
  logic [3:0]    reg_be_o;
  logic          reg_ready_i = 1'b0;
  logic [31:0]   reg_rdata_i = '0;
  logic          reg_error_i = 1'b0;

  always #5 clk = ~clk;

  tlul_reg_responder #(
    .AW       (AW),
    .RegBytes (RegBytes),
    .Timeout  (Timeout)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .tl_i        (tl_i),
    .tl_o        (tl_o),
    .reg_req_o   (reg_req_o),
    .reg_we_o    (reg_we_o),
    .reg_addr_o  (reg_addr_o),
    .reg_wdata_o (reg_wdata_o),
    .reg_be_o    (reg_be_o),
    .reg_ready_i (reg_ready_i),
    .reg_rdata_i (reg_rdata_i),
    .reg_error_i (reg_error_i)
  );

  typedef struct {
    logic [2:0]  op;
    logic [1:0]  size;
    logic [7:0]  src;
    logic [31:0] data;
    logic        err;
  } rsp_t;

  rsp_t q[$];
  int n_chk = 0;
  int n_fail = 0;
  int n_rsp = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Register-side peripheral model
  int          wait_k = 0;
  logic [31:0] rd = '0;
  logic        rerr = 1'b0;
  int          req_cyc = 0;
  logic        idle_ready = 1'b0;
  logic        exp_we;
  logic [7:0]  exp_addr;
  logic [31:0] exp_wdata;
  logic [3:0]  exp_be;

  always @(negedge clk) begin
    if (rst_ni && reg_req_o) begin
      req_cyc++;
      chk("reg_we", 32'(reg_we_o), 32'(exp_we));
      chk("reg_addr", 32'(reg_addr_o), 32'(exp_addr));
      chk("reg_wdata", reg_wdata_o, exp_wdata);
      chk("reg_be", 32'(reg_be_o), 32'(exp_be));
      reg_ready_i = (req_cyc - 1 == wait_k);
      reg_rdata_i = reg_ready_i ? rd : 32'h0BAD_0BAD;
      reg_error_i = reg_ready_i & rerr;
    end else begin
      reg_ready_i = idle_ready;
      reg_rdata_i = 32'h5555_5555;
      reg_error_i = idle_ready;
    end
  end

  // D-channel monitor: pops on first valid cycle, then checks hold
  rsp_t snap;
  logic pend = 1'b0;

  always @(negedge clk) begin
    if (!rst_ni) begin
      pend = 1'b0;
    end else if (tl_o.d_valid) begin
      if (!pend) begin
        n_rsp++;
        if (q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_rsp: got src %h expected none",
                   tl_o.d_source);
        end else begin
          snap = q.pop_front();
          pend = 1'b1;
        end
      end
      if (pend) begin
        chk("d_opcode", 32'(tl_o.d_opcode), 32'(snap.op));
        chk("d_size", 32'(tl_o.d_size), 32'(snap.size));
        chk("d_source", 32'(tl_o.d_source), 32'(snap.src));
        chk("d_data", tl_o.d_data, snap.data);
        chk("d_error", 32'(tl_o.d_error), 32'(snap.err));
        chk("d_zero", 32'({tl_o.d_param, tl_o.d_sink,
                          tl_o.d_user}), 32'h0);
        chk("a_ready_busy", 32'(tl_o.a_ready), 32'h0);
      end
      if (tl_i.d_ready) pend = 1'b0;
    end
  end

  task automatic issue(input logic [2:0] op,
                       input logic [1:0] sz,
                       input logic [7:0] src,
                       input logic [31:0] addr,
                       input logic [3:0] mask,
                       input logic [31:0] data,
                       input int acc_wait,
                       input int lat,
                       input string nm);
    int n;
    tl_i.a_valid   = 1'b1;
    tl_i.a_opcode  = op;
    tl_i.a_param   = 3'h0;
    tl_i.a_size    = sz;
    tl_i.a_source  = src;
    tl_i.a_address = addr;
    tl_i.a_mask    = mask;
    tl_i.a_data    = data;
    n = 0;
    while (!tl_o.a_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_acc_wait"}, 32'(n), 32'(acc_wait));
    @(posedge clk);
    #1 tl_i.a_valid = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!tl_o.d_valid && n < 300);
    chk({nm, "_lat"}, 32'(n), 32'(lat));
  endtask

  task automatic wait_done(input string nm);
    int n;
    n = 0;
    while (tl_o.d_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_done"}, 32'(tl_o.d_valid), 32'h0);
  endtask

  task automatic txn(input logic [2:0] op,
                     input logic [1:0] sz,
                     input logic [7:0] src,
                     input logic [31:0] addr,
                     input logic [3:0] mask,
                     input logic [31:0] data,
                     input int wk,
                     input logic [31:0] rdv,
                     input logic re,
                     input logic [2:0] eop,
                     input logic [31:0] edata,
                     input logic eerr,
                     input int lat,
                     input int ereq,
                     input string nm);
    rsp_t r;
    wait_k    = wk;
    rd        = rdv;
    rerr      = re;
    req_cyc   = 0;
    exp_we    = (op != Get);
    exp_addr  = {addr[7:2], 2'b00};
    exp_wdata = data;
    exp_be    = mask;
    r.op   = eop;
    r.size = sz;
    r.src  = src;
    r.data = edata;
    r.err  = eerr;
    q.push_back(r);
    issue(op, sz, src, addr, mask, data, 0, lat, nm);
    wait_done(nm);
    chk({nm, "_req_cycles"}, 32'(req_cyc), 32'(ereq));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rsp_t r;
    tl_i = '0;
    tl_i.d_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_a_ready", 32'(tl_o.a_ready), 32'h1);
    chk("rst_d_valid", 32'(tl_o.d_valid), 32'h0);
    chk("rst_reg_req", 32'(reg_req_o), 32'h0);
    chk("rst_d_fields", 32'({tl_o.d_opcode, tl_o.d_error,
                            tl_o.d_source}), 32'h0);
    chk("rst_d_data", tl_o.d_data, 32'h0);
    @(posedge clk);
    #2 rst_ni = 1'b1;
    @(negedge clk);

    // ready outside ACCESS must be ignored
    @(posedge clk);
    #1 idle_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_rdy_req", 32'(reg_req_o), 32'h0);
    chk("idle_rdy_dv", 32'(tl_o.d_valid), 32'h0);
    chk("idle_rdy_ar", 32'(tl_o.a_ready), 32'h1);
    @(posedge clk);
    #1 idle_ready = 1'b0;
    @(negedge clk);

    txn(Get, 2'd2, 8'h3C, 32'h10, 4'hF, 32'h0,
        0, 32'hA5A5_1234, 1'b0,
        AccessAckData, 32'hA5A5_1234, 1'b0, 2, 1, "get0");
    txn(PutFullData, 2'd2, 8'h21, 32'h04, 4'hF, 32'hDEAD_BEEF,
        3, 32'h0, 1'b0,
        AccessAck, 32'h0, 1'b0, 5, 4, "putfull");
    txn(PutFullData, 2'd2, 8'h01, 32'h00, 4'h3, 32'h1,
        0, 32'h0, 1'b0,
        AccessAck, 32'h0, 1'b1, 1, 0, "bad_fullmask");
    txn(Get, 2'd1, 8'h02, 32'h01, 4'h3, 32'h0,
        0, 32'h0, 1'b0,
        AccessAckData, 32'hFFFF_FFFF, 1'b1, 1, 0, "bad_align");
    txn(Get, 2'd2, 8'h03, 32'h40, 4'hF, 32'h0,
        0, 32'h0, 1'b0,
        AccessAckData, 32'hFFFF_FFFF, 1'b1, 1, 0, "bad_range");
    txn(3'h2, 2'd2, 8'h04, 32'h00, 4'hF, 32'h0,
        0, 32'h0, 1'b0,
        AccessAck, 32'h0, 1'b1, 1, 0, "bad_opcode");
    txn(Get, 2'd2, 8'h55, 32'h08, 4'hF, 32'h0,
        -1, 32'h0, 1'b0,
        AccessAckData, 32'hFFFF_FFFF, 1'b1, Timeout + 1,
        Timeout, "timeout");
    txn(Get, 2'd2, 8'h56, 32'h08, 4'hF, 32'h0,
        0, 32'h7777_0001, 1'b0,
        AccessAckData, 32'h7777_0001, 1'b0, 2, 1, "after_to");
    txn(Get, 2'd2, 8'h60, 32'h30, 4'hF, 32'h0,
        0, 32'h1234_5678, 1'b1,
        AccessAckData, 32'hFFFF_FFFF, 1'b1, 2, 1, "reg_err");
    txn(PutPartialData, 2'd2, 8'h61, 32'h3C, 4'h6, 32'h1234_5678,
        2, 32'h0, 1'b0,
        AccessAck, 32'h0, 1'b0, 4, 3, "partial_top");
    txn(Get, 2'd0, 8'h07, 32'h3F, 4'h8, 32'h0,
        0, 32'hCAFE_F00D, 1'b0,
        AccessAckData, 32'hCAFE_F00D, 1'b0, 2, 1, "byte_get");

    // d_ready stall with a second request queued behind it
    @(posedge clk);
    #1 tl_i.d_ready = 1'b0;
    @(negedge clk);
    wait_k    = 0;
    rd        = 32'h1111_2222;
    rerr      = 1'b0;
    req_cyc   = 0;
    exp_we    = 1'b0;
    exp_addr  = 8'h08;
    exp_wdata = 32'h0;
    exp_be    = 4'hF;
    r = '{AccessAckData, 2'd2, 8'h11, 32'h1111_2222, 1'b0};
    q.push_back(r);
    r = '{AccessAckData, 2'd2, 8'h12, 32'h3333_4444, 1'b0};
    q.push_back(r);
    issue(Get, 2'd2, 8'h11, 32'h08, 4'hF, 32'h0, 0, 2, "stallA");
    rd       = 32'h3333_4444;
    req_cyc  = 0;
    exp_addr = 8'h0C;
    fork
      issue(Get, 2'd2, 8'h12, 32'h0C, 4'hF, 32'h0, 6, 2, "stallB");
      begin
        repeat (5) @(posedge clk);
        #1 tl_i.d_ready = 1'b1;
      end
    join
    wait_done("stallB");

    // asynchronous reset in the middle of an access
    wait_k  = -1;
    req_cyc = 0;
    exp_we  = 1'b0;
    exp_addr = 8'h20;
    exp_wdata = 32'h0;
    exp_be  = 4'hF;
    tl_i.a_valid   = 1'b1;
    tl_i.a_opcode  = Get;
    tl_i.a_size    = 2'd2;
    tl_i.a_source  = 8'h99;
    tl_i.a_address = 32'h20;
    tl_i.a_mask    = 4'hF;
    tl_i.a_data    = 32'h0;
    @(posedge clk);
    #1 tl_i.a_valid = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst_ni = 1'b0;
    #1;
    chk("arst_reg_req", 32'(reg_req_o), 32'h0);
    chk("arst_d_valid", 32'(tl_o.d_valid), 32'h0);
    chk("arst_req_cyc", 32'(req_cyc), 32'h3);
    @(posedge clk);
    #2 rst_ni = 1'b1;
    repeat (5) @(negedge clk);
    chk("post_rst_a_ready", 32'(tl_o.a_ready), 32'h1);
    chk("post_rst_req", 32'(reg_req_o), 32'h0);
    chk("post_rst_dv", 32'(tl_o.d_valid), 32'h0);

    txn(Get, 2'd2, 8'h9A, 32'h24, 4'hF, 32'h0,
        1, 32'h0F0F_0F0F, 1'b0,
        AccessAckData, 32'h0F0F_0F0F, 1'b0, 3, 2, "post_rst");

    repeat (3) @(negedge clk);
    chk("rsp_count", 32'(n_rsp), 32'd14);
    chk("queue_empty", 32'(q.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
